store_narrow_buf: RTL and testbench
===================================

STORE_NARROW_BUF -- requirements
Module: store_narrow_buf

Interface
REQ-001 Parameter DEPTH, default 4, buffer entries; SHALL be a power of two, range 2..16.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 st_valid  input  1  pipeline presents a store.
REQ-005 st_ready  output  1  buffer accepts the store this cycle.
REQ-006 st_addr  input  32  byte address of the store.
REQ-007 st_data  input  32  register value; the low byte, halfword or full word is stored.
REQ-008 st_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 mem_valid  output  1  head entry presented to data memory.
REQ-010 mem_ready  input  1  memory consumes the head entry.
REQ-011 mem_addr  output  32  word-aligned address; bits [1:0] SHALL always be 0.
REQ-012 mem_wdata  output  32  lane-aligned write data.
REQ-013 mem_be  output  4  byte enables; bit n enables mem_wdata[8n+7:8n].
REQ-014 buf_empty  output  1  no entries held.
REQ-015 st_fault  output  1  one-cycle pulse: store rejected (misaligned or reserved size).

Function
REQ-016 The store handshake SHALL complete when st_valid && st_ready; the memory handshake SHALL complete when mem_valid && mem_ready.
REQ-017 st_ready SHALL be 1 exactly when count < DEPTH; it SHALL not depend combinationally on mem_ready.
REQ-018 Narrowing, byte: the data lane SHALL be st_data[7:0] replicated to all four lanes, and mem_be SHALL be 0001 shifted left by st_addr[1:0].
REQ-019 Narrowing, halfword: the data lane SHALL be st_data[15:0] replicated to both halves, and mem_be SHALL be 0011 shifted left by st_addr[1:0].
REQ-020 Narrowing, word: the data lane SHALL be st_data, and mem_be SHALL be 1111.
REQ-021 Upper source bits above the stored width SHALL be discarded, not sign- or zero-checked.
REQ-022 Each entry SHALL hold {addr[31:2], wdata, be}; entries SHALL drain in FIFO order.
REQ-023 Latency: an entry accepted in cycle N SHALL first drive mem_valid in cycle N+1 when the buffer was empty; there SHALL be no combinational bypass.
REQ-024 mem_valid SHALL equal !buf_empty. The mem_addr, mem_wdata and mem_be outputs SHALL hold stable while mem_valid && !mem_ready.
REQ-025 Simultaneous accept and drain SHALL leave count unchanged and SHALL be legal at any occupancy below DEPTH.
REQ-026 At full, a drain SHALL raise st_ready in the following cycle only.
REQ-027 Pointers SHALL wrap modulo DEPTH, and count SHALL use log2(DEPTH)+1 bits.
REQ-028 A reserved st_size (11) SHALL never write an entry, SHALL pulse st_fault for one cycle, and SHALL still complete the handshake (st_ready follows REQ-017).
REQ-029 A faulted store SHALL not alter count or pointers.

Reset
REQ-030 When rst=1 at a clock edge: count=0, read and write pointers=0, and st_fault=0.
REQ-031 Outputs in the cycle after reset: mem_valid=0, buf_empty=1, st_ready=1, and mem_addr, mem_wdata and mem_be = 0.
REQ-032 Reset mid-operation SHALL discard all pending entries without issuing them; reset SHALL take priority over simultaneous handshakes.

Configuration
REQ-033 Macro STBUF_MISALIGN_TRAP_EN.
- Defined: a halfword with st_addr[0]=1, or a word with st_addr[1:0]!=00, SHALL be rejected as in REQ-028/029.
- Undefined: the misaligned low address bits SHALL be forced to alignment (halfword clears bit 0; word clears bits 1:0) before lane selection, and the store SHALL be buffered. st_fault SHALL then pulse only for a reserved size.

Verification
REQ-034 Byte store: addr=0x1003, data=0xAABBCC5A -> one cycle later mem_addr=0x1000, mem_be=1000, and mem_wdata[31:24]=0x5A.
REQ-035 Halfword store: addr=0x2002, data=0x1234BEEF -> mem_be=1100, mem_wdata[31:16]=0xBEEF, and mem_addr=0x2000.
REQ-036 Fill: DEPTH=4 and mem_ready=0, push 5 word stores -> st_ready=0 after the 4th accept. Then pulse mem_ready for one cycle -> the 1st entry drains and st_ready=1 on the next cycle. All 4 entries then emerge in order.
REQ-037 Streaming: st_valid=1 and mem_ready=1 for 20 cycles -> count stays at 1 after the first cycle and throughput is one store per cycle.
REQ-038 Misaligned word at addr=0x3001:
- With STBUF_MISALIGN_TRAP_EN: st_fault pulses once and buf_empty stays 1.
- Without it: an entry is issued with mem_addr=0x3000 and mem_be=1111.
REQ-039 Reset: assert rst with 3 entries held -> next cycle mem_valid=0, buf_empty=1, and no held entry is ever presented.

Source files
------------

// File: rtl/store_narrow_buf.sv
// -----------------------------------------------------------------------------
// store_narrow_buf
//
// Store buffer that narrows byte / halfword / word stores from the pipeline
// into lane-aligned, byte-enabled word writes, and queues them in FIFO order
// towards data memory.
//
// Parameters
//   DEPTH      number of buffered entries (power of two, 2..16)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   st_valid   pipeline presents a store
//   st_ready   buffer accepts the store this cycle (count < DEPTH)
//   st_addr    byte address of the store
//   st_data    register value (low byte / halfword / word is stored)
//   st_size    00 byte, 01 halfword, 10 word, 11 reserved
//   mem_valid  head entry presented to data memory
//   mem_ready  memory consumes the head entry
//   mem_addr   word-aligned write address
//   mem_wdata  lane-aligned write data
//   mem_be     byte enables (bit n covers mem_wdata[8n+7:8n])
//   buf_empty  no entries held
//   st_fault   one-cycle pulse after a rejected store
//
// Build option
//   STBUF_MISALIGN_TRAP_EN  defined: misaligned halfword/word stores are
//                           rejected like a reserved size. Undefined: the
//                           low address bits are forced to alignment and the
//                           store is buffered.
// -----------------------------------------------------------------------------
module store_narrow_buf #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        buf_empty,
    output logic        st_fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Store side: st_ready depends only on registered occupancy, so a store
    // that is offered while the buffer is full simply waits. Memory side:
    // the head entry is held stable until mem_ready is seen with mem_valid.

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          fault_q;

    logic [29:0] addr_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];
    logic [3:0]  be_mem   [DEPTH];

    logic [31:0] n_wdata;
    logic [3:0]  n_be;
    logic        bad;
    logic        st_accept;
    logic        push;
    logic        pop;

    // Lane narrowing. Bits above the stored width are dropped silently.
    always_comb begin
        n_wdata = '0;
        n_be    = '0;
        bad     = 1'b0;
        case (st_size)
            2'b00: begin
                n_wdata = {4{st_data[7:0]}};
                n_be    = 4'b0001 << st_addr[1:0];
            end
            2'b01: begin
`ifdef STBUF_MISALIGN_TRAP_EN
                bad     = st_addr[0];
`endif
                // Only addr[1] picks the half, which is the same as
                // clearing a misaligned bit 0.
                n_wdata = {2{st_data[15:0]}};
                n_be    = st_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
`ifdef STBUF_MISALIGN_TRAP_EN
                bad     = |st_addr[1:0];
`endif
                n_wdata = st_data;
                n_be    = 4'b1111;
            end
            default: begin
                bad     = 1'b1;
            end
        endcase
    end

    assign st_ready  = (count < CW'(DEPTH));
    assign buf_empty = (count == '0);
    assign mem_valid = !buf_empty;

    // A rejected store still completes its handshake but writes nothing.
    assign st_accept = st_valid && st_ready;
    assign push      = st_accept && !bad;
    assign pop       = mem_valid && mem_ready;

    // Outputs are zero while nothing is held so stale array contents
    // (including entries discarded by reset) are never visible.
    assign mem_addr  = mem_valid ? {addr_mem[rd_ptr], 2'b00} : 32'h0;
    assign mem_wdata = mem_valid ? data_mem[rd_ptr] : 32'h0;
    assign mem_be    = mem_valid ? be_mem[rd_ptr] : 4'h0;
    assign st_fault  = fault_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            fault_q <= 1'b0;
        end else begin
            fault_q <= st_accept && bad;
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            addr_mem[wr_ptr] <= st_addr[31:2];
            data_mem[wr_ptr] <= n_wdata;
            be_mem[wr_ptr]   <= n_be;
        end
    end

endmodule

// File: tb/tb_store_narrow_buf.sv
// -----------------------------------------------------------------------------
// tb_store_narrow_buf
//
// Directed bench for store_narrow_buf (DEPTH = 4). Inputs change and outputs
// are sampled on the falling edge; the DUT updates on the rising edge.
// -----------------------------------------------------------------------------
module tb_store_narrow_buf;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        buf_empty;
    logic        st_fault;

    int checks = 0;
    int errors = 0;

    logic [67:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        logic        e_fault;
    } vec_t;

    vec_t vecs[9];

    store_narrow_buf #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_size   (st_size),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .buf_empty (buf_empty),
        .st_fault  (st_fault)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_size  = s;
    endtask

    task automatic idle_store();
        st_valid = 1'b0;
        st_addr  = 32'h0;
        st_data  = 32'h0;
        st_size  = 2'b00;
    endtask

    function automatic logic [67:0] word_entry(input logic [31:0] a, input logic [31:0] d);
        return {a, d, 4'b1111};
    endfunction

    initial begin
        // vector table: addr, data, size, expected addr/wdata/be/fault
        vecs[0] = '{32'h0000_1003, 32'hAABB_CC5A, 2'b00, 32'h0000_1000, 32'h5A5A_5A5A, 4'b1000, 1'b0};
        vecs[1] = '{32'h0000_2002, 32'h1234_BEEF, 2'b01, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100, 1'b0};
        vecs[2] = '{32'h0000_4000, 32'hDEAD_BEEF, 2'b10, 32'h0000_4000, 32'hDEAD_BEEF, 4'b1111, 1'b0};
        vecs[3] = '{32'h0000_5000, 32'h0000_0011, 2'b00, 32'h0000_5000, 32'h1111_1111, 4'b0001, 1'b0};
        vecs[4] = '{32'h0000_5001, 32'hFFFF_FF22, 2'b00, 32'h0000_5000, 32'h2222_2222, 4'b0010, 1'b0};
        vecs[5] = '{32'h0000_6000, 32'hFFFF_0F0F, 2'b01, 32'h0000_6000, 32'h0F0F_0F0F, 4'b0011, 1'b0};
`ifdef STBUF_MISALIGN_TRAP_EN
        vecs[6] = '{32'h0000_6003, 32'h0000_ABCD, 2'b01, 32'h0, 32'h0, 4'b0000, 1'b1};
        vecs[7] = '{32'h0000_3001, 32'h0102_0304, 2'b10, 32'h0, 32'h0, 4'b0000, 1'b1};
`else
        vecs[6] = '{32'h0000_6003, 32'h0000_ABCD, 2'b01, 32'h0000_6000, 32'hABCD_ABCD, 4'b1100, 1'b0};
        vecs[7] = '{32'h0000_3001, 32'h0102_0304, 2'b10, 32'h0000_3000, 32'h0102_0304, 4'b1111, 1'b0};
`endif
        vecs[8] = '{32'h0000_7000, 32'h5555_5555, 2'b11, 32'h0, 32'h0, 4'b0000, 1'b1};

        rst       = 1'b1;
        mem_ready = 1'b0;
        idle_store();
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_buf_empty", buf_empty, 1);
        chk("rst_st_ready",  st_ready, 1);
        chk("rst_st_fault",  st_fault, 0);
        chk("rst_outputs",   {mem_addr, mem_wdata, mem_be}, 0);
        rst = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);

        // table-driven narrowing: accept, check one cycle later, then drain
        for (int i = 0; i < 9; i++) begin
            drive_store(vecs[i].addr, vecs[i].data, vecs[i].size);
            @(negedge clk);
            idle_store();
            chk($sformatf("v%0d_mem_valid", i), mem_valid, !vecs[i].e_fault);
            chk($sformatf("v%0d_buf_empty", i), buf_empty, vecs[i].e_fault);
            chk($sformatf("v%0d_entry", i), {mem_addr, mem_wdata, mem_be},
                {vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_be});
            chk($sformatf("v%0d_st_fault", i), st_fault, vecs[i].e_fault);
            @(negedge clk);
            chk($sformatf("v%0d_fault_clear", i), st_fault, 0);
            chk($sformatf("v%0d_drained", i), buf_empty, 1);
        end

        // fill: four word stores with memory stalled
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fill_ready_%0d", i), st_ready, 1);
            drive_store(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 2'b10);
            exp_q.push_back(word_entry(32'h100 + 32'(4 * i), 32'hA0 + 32'(i)));
            @(negedge clk);
        end
        chk("full_ready", st_ready, 0);
        chk("full_head", {mem_addr, mem_wdata, mem_be}, exp_q[0]);
        // fifth store is offered and must wait
        drive_store(32'h110, 32'hA4, 2'b10);
        @(negedge clk);
        chk("full_ready_hold", st_ready, 0);
        chk("full_head_stable", {mem_addr, mem_wdata, mem_be}, exp_q[0]);
        // one-cycle drain pulse; st_ready rises only afterwards
        mem_ready = 1'b1;
        chk("drain_head", {mem_addr, mem_wdata, mem_be}, exp_q.pop_front());
        @(negedge clk);
        mem_ready = 1'b0;
        chk("drain_ready_up", st_ready, 1);
        chk("drain_next_head", {mem_addr, mem_wdata, mem_be}, exp_q[0]);
        exp_q.push_back(word_entry(32'h110, 32'hA4));
        @(negedge clk);
        idle_store();
        chk("refill_ready", st_ready, 0);
        // drain everything in order, bounded
        mem_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            if (mem_valid)
                chk("drain_order", {mem_addr, mem_wdata, mem_be}, exp_q.pop_front());
            @(negedge clk);
        end
        if (exp_q.size() != 0)
            chk("drain_timeout", 68'(exp_q.size()), 0);
        chk("drain_empty", buf_empty, 1);
        exp_q.delete();

        // streaming: one store per cycle, occupancy stays at one
        for (int k = 0; k < 20; k++) begin
            if (k > 0) begin
                chk("stream_head", {mem_addr, mem_wdata, mem_be},
                    word_entry(32'h8000 + 32'(4 * (k - 1)), 32'hC000 + 32'(k - 1)));
                chk("stream_ready", st_ready, 1);
            end
            drive_store(32'h8000 + 32'(4 * k), 32'hC000 + 32'(k), 2'b10);
            @(negedge clk);
        end
        idle_store();
        chk("stream_last", {mem_addr, mem_wdata, mem_be}, word_entry(32'h8000 + 32'(4 * 19), 32'hC000 + 32'(19)));
        @(negedge clk);
        chk("stream_empty", buf_empty, 1);

        // reset with three entries held, colliding with both handshakes
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_store(32'h9000 + 32'(4 * i), 32'hD0 + 32'(i), 2'b10);
            @(negedge clk);
        end
        chk("pre_rst_valid", mem_valid, 1);
        rst = 1'b1;
        mem_ready = 1'b1;
        drive_store(32'h9100, 32'hEE, 2'b10);
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        idle_store();
        chk("mrst_mem_valid", mem_valid, 0);
        chk("mrst_buf_empty", buf_empty, 1);
        chk("mrst_st_ready",  st_ready, 1);
        chk("mrst_outputs",   {mem_addr, mem_wdata, mem_be}, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("mrst_never_issued", mem_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
